// File: rtl/config_loader_if.sv
// Bitstream word channel: the source drives data/valid, the loader returns ready.
interface config_loader_if #(
    parameter int IW = 8
);
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/config_loader.sv
// Assembles NWORDS bitstream words plus an XOR checksum into one CONF_WIDTH config word and commits it with cset.
// Latency: last payload transfer -> CHECK next cycle; checksum transfer -> cset next cycle; done one cycle after cset.
// Backpressure: in_ready is a pure function of state (high in LOAD/CHECK), so stalls only come from in_valid.
module config_loader #(
    parameter int CONF_WIDTH = 288,
    parameter int IW         = 8,
    parameter int NWORDS     = (CONF_WIDTH + IW - 1) / IW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    config_loader_if.slave        bus,
    output logic [CONF_WIDTH-1:0] c,
    output logic                  cset,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int CW = $clog2(NWORDS + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] CHECK  = 3'd2;
    localparam logic [2:0] COMMIT = 3'd3;
    localparam logic [2:0] ERROR  = 3'd4;

    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);
    localparam logic [CW-1:0] FULL = CW'(NWORDS);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_acc;
    logic          r_done;
    logic          w_ready;
    logic          w_accept;
    logic          w_load;
    logic          w_restart;
    logic          w_sum_ok;

    assign w_ready   = (r_state == LOAD) || (r_state == CHECK);
    // A word presented together with abort is dropped, not just its state effect.
    assign w_accept  = bus.in_valid && w_ready && !abort;
    assign w_load    = (r_state == LOAD) && w_accept;
    assign w_restart = ((r_state == IDLE) || (r_state == ERROR)) && start;
    assign w_sum_ok  = (bus.in_data == r_acc);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, ERROR: begin
                if (start) w_state_nxt = LOAD;
            end
            LOAD: begin
                if (abort)                       w_state_nxt = IDLE;
                else if (w_load && r_cnt == LAST) w_state_nxt = CHECK;
            end
            CHECK: begin
                if (abort)         w_state_nxt = IDLE;
                else if (w_accept) w_state_nxt = w_sum_ok ? COMMIT : ERROR;
            end
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_restart) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_load) begin
            r_acc <= r_acc ^ bus.in_data;
            if (r_cnt != FULL) r_cnt <= r_cnt + CW'(1);
        end
    end

    // One register slice per word slot; the top slot keeps only the bits that fit.
    for (genvar k = 0; k < NWORDS; k++) begin : g_slot
        localparam int LO = k * IW;
        localparam int W  = (CONF_WIDTH - LO < IW) ? (CONF_WIDTH - LO) : IW;

        logic [W-1:0] r_slot;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_slot <= '0;
            end else if (w_load && r_cnt == CW'(k)) begin
                r_slot <= bus.in_data[W-1:0];
            end
        end

        assign c[LO +: W] = r_slot;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == COMMIT);
        end
    end

    // cset and in_ready come straight from state so reset drops them without a clock.
    assign bus.in_ready = w_ready;
    assign cset         = (r_state == COMMIT);
    assign busy         = (r_state == LOAD) || (r_state == CHECK) || (r_state == COMMIT);
    assign err          = (r_state == ERROR);
    assign done         = r_done;
endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The module SHALL have parameter CONF_WIDTH, default 288, the width of the parallel configuration word delivered to one fabric block.
REQ-002 The module SHALL have parameter IW, default 8, the width of each incoming bitstream word.
REQ-003 The module SHALL have derived parameter NWORDS, default ceil(CONF_WIDTH/IW) = 36, the number of payload words per load.
REQ-004 The module SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, width 1: asynchronous, active-low reset.
REQ-006 The module SHALL have port start, input, width 1: request to begin a load.
REQ-007 The module SHALL have port abort, input, width 1: cancel a load in progress.
REQ-008 The module SHALL have port in_data, input, width IW: the bitstream word.
REQ-009 The module SHALL have port in_valid, input, width 1: in_data is valid.
REQ-010 The module SHALL have port in_ready, output, width 1: the loader accepts in_data this cycle.
REQ-011 The module SHALL have port c, output, width CONF_WIDTH: the assembled configuration, driven to the fabric block's c input.
REQ-012 The module SHALL have port cset, output, width 1: a one-cycle commit strobe, driven to the fabric block's cset input.
REQ-013 The module SHALL have port busy, output, width 1: high in LOAD, CHECK and COMMIT.
REQ-014 The module SHALL have port done, output, width 1: a one-cycle pulse after a successful commit.
REQ-015 The module SHALL have port err, output, width 1: sticky checksum-failure flag.

Function
REQ-016 States SHALL be IDLE, LOAD, CHECK, COMMIT and ERROR.
REQ-017 A word SHALL transfer only in a cycle where in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 only in LOAD and CHECK, and SHALL NOT depend combinationally on in_valid.
REQ-019 On start=1 in IDLE or ERROR, the loader SHALL enter LOAD next cycle, clear the word counter, clear the checksum accumulator and clear err.
REQ-020 start SHALL be ignored in LOAD, CHECK and COMMIT.
REQ-021 In LOAD, the k-th accepted word (k=0..NWORDS-1) SHALL be written to c[k*IW +: IW]; bits beyond CONF_WIDTH-1 in the last word SHALL be discarded.
REQ-022 Each accepted payload word SHALL be XORed into an IW-bit accumulator.
REQ-023 After the NWORDS-th payload transfer, the state SHALL be CHECK on the next cycle.
REQ-024 In CHECK, one transferred word SHALL be compared with the accumulator: equal -> COMMIT, unequal -> ERROR.
REQ-025 COMMIT SHALL last exactly one cycle with cset=1 and c stable, then go to IDLE with done=1 for exactly one cycle.
REQ-026 cset SHALL never be asserted outside COMMIT.
REQ-027 c MAY change during LOAD and SHALL hold its value in all other states.
REQ-028 ERROR SHALL hold err=1, with cset=0 and in_ready=0, until start or reset.
REQ-029 abort=1 in LOAD or CHECK SHALL return the loader to IDLE next cycle with no cset and no done; a word transferring in that same cycle SHALL be discarded.
REQ-030 abort SHALL be ignored in COMMIT, because commit is atomic.
REQ-031 The word counter SHALL be $clog2(NWORDS+1) bits wide, SHALL reset to 0 and SHALL never wrap.
REQ-032 Transfer-to-CHECK latency SHALL be 1 cycle; CHECK-transfer-to-cset latency SHALL be 1 cycle.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, c=0, cset=0, in_ready=0, busy=0, done=0, err=0, counter=0 and accumulator=0, regardless of clk.
REQ-034 Reset asserted mid-load or during COMMIT SHALL cancel the operation; cset SHALL deassert asynchronously.
REQ-035 Reset deassertion SHALL take effect on the next clk edge with no further required sequencing.

Verification (CONF_WIDTH=20, IW=8, NWORDS=3)
REQ-036 Nominal load: start, then words 0x34, 0x12, 0xFB, then checksum 0x34^0x12^0xFB=0xDD, all back-to-back -> c=20'hB1234, cset high exactly one cycle, done on the following cycle, err=0.
REQ-037 Bad checksum: the same payload followed by checksum 0x00 -> err=1, cset never asserted, c=20'hB1234 held; a subsequent start clears err.
REQ-038 Backpressure gaps: the nominal stream with in_valid low for 2 cycles between every word -> identical result to REQ-036; no word is duplicated or skipped.
REQ-039 Abort: assert abort in the same cycle as the second payload transfer -> IDLE, no cset and no done; a fresh nominal load afterwards succeeds.
REQ-040 Async reset mid-load: pull rst low between clk edges after 2 words -> all outputs reach their reset values before the next edge; start after release yields a clean load.
REQ-041 start held high throughout a nominal load -> ignored while busy; a new load begins in the cycle after done.
